// File: rtl/pong_ball_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : pong_ball_ctrl
// Brief    : Pong ball controller. Serve / rally / point / game-over state
//            machine with wall bounce, paddle contact, speed ramp and scoring.
// Options  : define PONG_BALL_SPIN_EN to let the paddle contact point steer
//            the ball vertically (middle third flattens the trajectory).
// Revision : 1.0 - initial release
//==============================================================================
module pong_ball_ctrl #(
  parameter int COORD_W       = 12,
  parameter int H_SIZE        = 10,
  parameter int V_SIZE        = 10,
  parameter int IX            = 320,
  parameter int IY            = 240,
  parameter int BAR_WIDTH     = 20,
  parameter int BAR_LENGTH    = 180,
  parameter int D_WIDTH       = 639,
  parameter int D_HEIGHT      = 470,
  parameter int SPEED_MIN     = 1,
  parameter int SPEED_MAX     = 6,
  parameter int HITS_PER_STEP = 4,
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_DELAY   = 60
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  input  logic               in_ani_stb,
  input  logic               in_start,
  input  logic               in_pause,
  input  logic [3:0]         in_random,
  input  logic [COORD_W-1:0] in_leftbar_top,
  input  logic [COORD_W-1:0] in_rightbar_top,
  output logic [COORD_W-1:0] out_x1,
  output logic [COORD_W-1:0] out_x2,
  output logic [COORD_W-1:0] out_y1,
  output logic [COORD_W-1:0] out_y2,
  output logic [SCORE_W-1:0] out_left_score,
  output logic [SCORE_W-1:0] out_right_score,
  output logic [3:0]         out_speed,
  output logic [2:0]         out_state,
  output logic               out_point,
  output logic [1:0]         out_winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int c_FRAME_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int c_HIT_W   = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
  localparam int c_CW1     = COORD_W + 1;

  localparam logic [COORD_W-1:0]   c_IX        = COORD_W'(IX);
  localparam logic [COORD_W-1:0]   c_IY        = COORD_W'(IY);
  localparam logic [COORD_W-1:0]   c_H_SIZE    = COORD_W'(H_SIZE);
  localparam logic [COORD_W-1:0]   c_V_SIZE    = COORD_W'(V_SIZE);
  localparam logic [COORD_W-1:0]   c_BAR_WIDTH = COORD_W'(BAR_WIDTH);
  localparam logic [COORD_W-1:0]   c_RIGHT_LIM = COORD_W'(D_WIDTH - BAR_WIDTH);
  localparam logic [COORD_W-1:0]   c_D_HEIGHT  = COORD_W'(D_HEIGHT);
  localparam logic [c_CW1-1:0]     c_BAR_LEN   = c_CW1'(BAR_LENGTH);
  localparam logic [3:0]           c_SPEED_MIN = 4'(SPEED_MIN);
  localparam logic [3:0]           c_SPEED_MAX = 4'(SPEED_MAX);
  localparam logic [c_HIT_W-1:0]   c_HIT_LAST  = c_HIT_W'(HITS_PER_STEP - 1);
  localparam logic [c_HIT_W-1:0]   c_HIT_ONE   = c_HIT_W'(1);
  localparam logic [c_FRAME_W-1:0] c_FRM_LAST  = c_FRAME_W'(SERVE_DELAY - 1);
  localparam logic [c_FRAME_W-1:0] c_FRM_ONE   = c_FRAME_W'(1);
  localparam logic [SCORE_W-1:0]   c_WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0]   c_SCORE_SAT = '1;
  localparam logic [SCORE_W-1:0]   c_SCORE_ONE = SCORE_W'(1);

  // Registered state
  state_t               r_state;
  logic [COORD_W-1:0]   r_x, r_y;
  logic                 r_x_dir, r_y_dir;
  logic                 r_y_frozen;
  logic [3:0]           r_speed;
  logic [c_HIT_W-1:0]   r_hits;
  logic [c_FRAME_W-1:0] r_frame;
  logic [SCORE_W-1:0]   r_left_score, r_right_score;
  logic                 r_point;
  logic [1:0]           r_winner;

  // Next-state values
  state_t               w_state_nxt;
  logic [COORD_W-1:0]   w_x_nxt, w_y_nxt;
  logic                 w_x_dir_nxt, w_y_dir_nxt, w_y_dir_b;
  logic                 w_y_frozen_nxt;
  logic [3:0]           w_speed_nxt;
  logic [c_HIT_W-1:0]   w_hits_nxt;
  logic [c_FRAME_W-1:0] w_frame_nxt;
  logic [SCORE_W-1:0]   w_left_score_nxt, w_right_score_nxt;
  logic                 w_point_nxt;
  logic [1:0]           w_winner_nxt;
  logic                 w_miss;

  // Contact / bounce helpers
  logic [COORD_W-1:0] w_speed_c;
  logic [c_CW1-1:0]   w_lbar_bot, w_rbar_bot;
  logic               w_top_bounce, w_bot_bounce;
  logic               w_left_contact, w_right_contact;
  logic               w_left_hit, w_right_hit;

  // Ball edges are pure arithmetic on the centre, wrapped to COORD_W bits
  assign out_x1 = r_x - c_H_SIZE;
  assign out_x2 = r_x + c_H_SIZE;
  assign out_y1 = r_y - c_V_SIZE;
  assign out_y2 = r_y + c_V_SIZE;

  assign w_speed_c  = COORD_W'(r_speed);
  // One extra bit keeps paddle bottoms from wrapping near the coordinate limit
  assign w_lbar_bot = {1'b0, in_leftbar_top} + c_BAR_LEN;
  assign w_rbar_bot = {1'b0, in_rightbar_top} + c_BAR_LEN;

  assign w_top_bounce    = (out_y1 <= w_speed_c);
  assign w_bot_bounce    = (out_y2 >= (c_D_HEIGHT - w_speed_c));
  assign w_left_contact  = (out_x1 <= c_BAR_WIDTH) && r_x_dir;
  assign w_right_contact = (out_x2 >= c_RIGHT_LIM) && !r_x_dir;
  assign w_left_hit      = (out_y2 >= in_leftbar_top) && ({1'b0, out_y1} <= w_lbar_bot);
  assign w_right_hit     = (out_y2 >= in_rightbar_top) && ({1'b0, out_y1} <= w_rbar_bot);

`ifdef PONG_BALL_SPIN_EN
  localparam logic [c_CW1-1:0] c_THIRD     = c_CW1'(BAR_LENGTH / 3);
  localparam logic [c_CW1-1:0] c_TWO_THIRD = c_CW1'((2 * BAR_LENGTH) / 3);
  logic w_left_mid, w_right_mid;
  assign w_left_mid  = ({1'b0, r_y} >= ({1'b0, in_leftbar_top} + c_THIRD)) &&
                       ({1'b0, r_y} <  ({1'b0, in_leftbar_top} + c_TWO_THIRD));
  assign w_right_mid = ({1'b0, r_y} >= ({1'b0, in_rightbar_top} + c_THIRD)) &&
                       ({1'b0, r_y} <  ({1'b0, in_rightbar_top} + c_TWO_THIRD));
`else
  logic w_unused_spin;
  assign w_unused_spin = ^in_random[3:2];
`endif

  // Next-state and datapath decode; in_start overrides every other event
  always_comb begin
    w_state_nxt       = r_state;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_x_dir_nxt       = r_x_dir;
    w_y_dir_nxt       = r_y_dir;
    w_y_dir_b         = r_y_dir;
    w_y_frozen_nxt    = r_y_frozen;
    w_speed_nxt       = r_speed;
    w_hits_nxt        = r_hits;
    w_frame_nxt       = r_frame;
    w_left_score_nxt  = r_left_score;
    w_right_score_nxt = r_right_score;
    w_point_nxt       = 1'b0;
    w_winner_nxt      = r_winner;
    w_miss            = 1'b0;

    if (in_start) begin
      w_state_nxt       = S_SERVE;
      w_x_nxt           = c_IX;
      w_y_nxt           = c_IY;
      w_speed_nxt       = c_SPEED_MIN;
      w_hits_nxt        = '0;
      w_frame_nxt       = '0;
      w_y_frozen_nxt    = 1'b0;
      w_left_score_nxt  = '0;
      w_right_score_nxt = '0;
      w_winner_nxt      = 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_x_nxt = c_IX;
          w_y_nxt = c_IY;
        end
        S_SERVE: begin
          w_x_nxt        = c_IX;
          w_y_nxt        = c_IY;
          w_speed_nxt    = c_SPEED_MIN;
          w_hits_nxt     = '0;
          w_y_frozen_nxt = 1'b0;
          if (in_ani_stb) begin
            if (r_frame == c_FRM_LAST) begin
              w_state_nxt = S_PLAY;
              w_frame_nxt = '0;
              w_x_dir_nxt = in_random[0];
              w_y_dir_nxt = in_random[1];
            end else begin
              w_frame_nxt = r_frame + c_FRM_ONE;
            end
          end
        end
        S_PLAY: begin
          if (in_ani_stb && !in_pause) begin
            if (w_top_bounce) w_y_dir_b = 1'b0;
            if (w_bot_bounce) w_y_dir_b = 1'b1;

            if (w_left_contact || w_right_contact) begin
              if ((w_left_contact && w_left_hit) || (w_right_contact && w_right_hit)) begin
                w_x_dir_nxt = w_left_contact ? 1'b0 : 1'b1;
                if (r_hits == c_HIT_LAST) begin
                  w_hits_nxt = '0;
                  if (r_speed < c_SPEED_MAX) w_speed_nxt = r_speed + 4'd1;
                end else begin
                  w_hits_nxt = r_hits + c_HIT_ONE;
                end
`ifdef PONG_BALL_SPIN_EN
                if (w_left_contact ? w_left_mid : w_right_mid) begin
                  w_y_frozen_nxt = 1'b1;
                end else begin
                  w_y_frozen_nxt = 1'b0;
                  w_y_dir_b      = w_left_contact ? in_random[2] : in_random[3];
                end
`endif
              end else begin
                w_miss = 1'b1;
                if (w_left_contact) begin
                  if (r_right_score != c_SCORE_SAT) w_right_score_nxt = r_right_score + c_SCORE_ONE;
                end else begin
                  if (r_left_score != c_SCORE_SAT) w_left_score_nxt = r_left_score + c_SCORE_ONE;
                end
              end
            end

            w_y_dir_nxt = w_y_dir_b;
            if (w_miss) begin
              w_point_nxt = 1'b1;
              w_x_nxt     = c_IX;
              w_y_nxt     = c_IY;
              w_state_nxt = S_POINT;
            end else begin
              w_x_nxt = w_x_dir_nxt ? (r_x - w_speed_c) : (r_x + w_speed_c);
              if (!w_y_frozen_nxt) begin
                w_y_nxt = w_y_dir_b ? (r_y - w_speed_c) : (r_y + w_speed_c);
              end
            end
          end
        end
        S_POINT: begin
          if (r_left_score == c_WIN || r_right_score == c_WIN) begin
            w_state_nxt  = S_OVER;
            w_winner_nxt = (r_left_score == c_WIN) ? 2'b01 : 2'b10;
          end else begin
            w_state_nxt = S_SERVE;
            w_frame_nxt = '0;
            w_speed_nxt = c_SPEED_MIN;
            w_hits_nxt  = '0;
          end
        end
        S_OVER: begin
          w_x_nxt = c_IX;
          w_y_nxt = c_IY;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Ball position, direction, speed, counters and score registers
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_x           <= c_IX;
      r_y           <= c_IY;
      r_x_dir       <= 1'b0;
      r_y_dir       <= 1'b0;
      r_y_frozen    <= 1'b0;
      r_speed       <= c_SPEED_MIN;
      r_hits        <= '0;
      r_frame       <= '0;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_point       <= 1'b0;
      r_winner      <= 2'b00;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_x_dir       <= w_x_dir_nxt;
      r_y_dir       <= w_y_dir_nxt;
      r_y_frozen    <= w_y_frozen_nxt;
      r_speed       <= w_speed_nxt;
      r_hits        <= w_hits_nxt;
      r_frame       <= w_frame_nxt;
      r_left_score  <= w_left_score_nxt;
      r_right_score <= w_right_score_nxt;
      r_point       <= w_point_nxt;
      r_winner      <= w_winner_nxt;
    end
  end

  assign out_left_score  = r_left_score;
  assign out_right_score = r_right_score;
  assign out_speed       = r_speed;
  assign out_state       = r_state;
  assign out_point       = r_point;
  assign out_winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_pong_ball_ctrl
// Brief    : Scoreboard bench for pong_ball_ctrl: directed serve, pause,
//            rally speed ramp, miss, match win, restart and async reset.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pong_ball_ctrl;

  localparam int c_SEL_STATE = 0;
  localparam int c_SEL_X1    = 1;
  localparam int c_SEL_X2    = 2;
  localparam int c_SEL_Y1    = 3;
  localparam int c_SEL_Y2    = 4;
  localparam int c_SEL_LSC   = 5;
  localparam int c_SEL_RSC   = 6;
  localparam int c_SEL_SPEED = 7;
  localparam int c_SEL_POINT = 8;
  localparam int c_SEL_WIN   = 9;

  logic        in_clock = 1'b0;
  logic        in_reset_n;
  logic        in_ani_stb;
  logic        in_start;
  logic        in_pause;
  logic [3:0]  in_random;
  logic [11:0] in_leftbar_top;
  logic [11:0] in_rightbar_top;
  logic [11:0] out_x1, out_x2, out_y1, out_y2;
  logic [3:0]  out_left_score, out_right_score;
  logic [3:0]  out_speed;
  logic [2:0]  out_state;
  logic        out_point;
  logic [1:0]  out_winner;

  pong_ball_ctrl dut (
    .in_clock        (in_clock),
    .in_reset_n      (in_reset_n),
    .in_ani_stb      (in_ani_stb),
    .in_start        (in_start),
    .in_pause        (in_pause),
    .in_random       (in_random),
    .in_leftbar_top  (in_leftbar_top),
    .in_rightbar_top (in_rightbar_top),
    .out_x1          (out_x1),
    .out_x2          (out_x2),
    .out_y1          (out_y1),
    .out_y2          (out_y2),
    .out_left_score  (out_left_score),
    .out_right_score (out_right_score),
    .out_speed       (out_speed),
    .out_state       (out_state),
    .out_point       (out_point),
    .out_winner      (out_winner)
  );

  always #5 in_clock = ~in_clock;

  // Scoreboard
  string q_nm[$];
  int    q_sel[$];
  int    q_val[$];
  event  chk_ev;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic int actual(input int sel);
    case (sel)
      c_SEL_STATE: return int'(out_state);
      c_SEL_X1:    return int'(out_x1);
      c_SEL_X2:    return int'(out_x2);
      c_SEL_Y1:    return int'(out_y1);
      c_SEL_Y2:    return int'(out_y2);
      c_SEL_LSC:   return int'(out_left_score);
      c_SEL_RSC:   return int'(out_right_score);
      c_SEL_SPEED: return int'(out_speed);
      c_SEL_POINT: return int'(out_point);
      c_SEL_WIN:   return int'(out_winner);
      default:     return -1;
    endcase
  endfunction

  task automatic expect_val(input string nm, input int sel, input int val);
    q_nm.push_back(nm);
    q_sel.push_back(sel);
    q_val.push_back(val);
    -> chk_ev;
  endtask

  task automatic expect_centre(input string nm);
    expect_val({nm, "_x1"}, c_SEL_X1, 310);
    expect_val({nm, "_x2"}, c_SEL_X2, 330);
    expect_val({nm, "_y1"}, c_SEL_Y1, 230);
    expect_val({nm, "_y2"}, c_SEL_Y2, 250);
  endtask

  task automatic bound_fail(input string nm, input int got, input int lim);
    n_vec++;
    n_err++;
    $display("FAIL %s: loop ran %0d iterations, required to finish within %0d", nm, got, lim);
  endtask

  // Monitor: drains expectations and compares against the live outputs
  always begin
    @(chk_ev or negedge in_clock);
    while (q_sel.size() > 0) begin
      string nm;
      int    sel, ev, av;
      nm  = q_nm.pop_front();
      sel = q_sel.pop_front();
      ev  = q_val.pop_front();
      av  = actual(sel);
      n_vec++;
      if (av != ev) begin
        n_err++;
        $display("FAIL %s: got %0d, expected %0d", nm, av, ev);
      end
    end
  end

  task automatic tick(input bit stb);
    in_ani_stb = stb;
    @(posedge in_clock);
    #1;
    in_ani_stb = 1'b0;
  endtask

  // Paddle top that keeps the ball centre on the paddle
  function automatic int track();
    int c;
    c = int'(out_y1) + 10 - 90;
    if (c < 0)   c = 0;
    if (c > 290) c = 290;
    return c;
  endfunction

  // Paddle top guaranteed to miss the ball
  function automatic int avoid();
    return ((int'(out_y1) + 10) >= 235) ? 0 : 290;
  endfunction

  // Serve (if needed) and rally until the chosen side misses
  task automatic run_to_point(input bit miss_left, input string nm);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 4000) begin
      in_leftbar_top  = 12'(miss_left ? avoid() : track());
      in_rightbar_top = 12'(miss_left ? track() : avoid());
      tick(1'b1);
      if (out_state == 3'd3) done = 1'b1;
      else begin
        tick(1'b0);
        n++;
      end
    end
    if (!done) bound_fail(nm, n, 4000);
  endtask

  initial begin
    int hits, n, prev_x, prev_dx, dx, exp_spd;

    in_reset_n      = 1'b0;
    in_ani_stb      = 1'b0;
    in_start        = 1'b0;
    in_pause        = 1'b0;
    in_random       = 4'b0000;
    in_leftbar_top  = 12'd200;
    in_rightbar_top = 12'd200;
    @(posedge in_clock); #1;
    @(posedge in_clock); #1;

    // Reset values
    expect_val("rst_state", c_SEL_STATE, 0);
    expect_centre("rst_ball");
    expect_val("rst_lscore", c_SEL_LSC, 0);
    expect_val("rst_rscore", c_SEL_RSC, 0);
    expect_val("rst_speed", c_SEL_SPEED, 1);
    expect_val("rst_point", c_SEL_POINT, 0);
    expect_val("rst_winner", c_SEL_WIN, 0);

    // Strobes in IDLE are ignored
    in_reset_n = 1'b1;
    tick(1'b1);
    tick(1'b0);
    expect_val("idle_state", c_SEL_STATE, 0);
    expect_centre("idle_ball");

    in_start = 1'b1;
    tick(1'b0);
    in_start = 1'b0;
    expect_val("start_state", c_SEL_STATE, 1);

    // Serve: 60 strobes, leave heading left/down
    in_random = 4'b0001;
    for (int i = 1; i <= 60; i++) begin
      tick(1'b1);
      if (i < 60) begin
        expect_val("serve_state", c_SEL_STATE, 1);
        if (i == 1 || i == 59) expect_centre("serve_ball");
      end else begin
        expect_val("serve_to_play", c_SEL_STATE, 2);
        expect_centre("play_entry_ball");
      end
      tick(1'b0);
    end

    // First move: x 320->319, y 240->241
    tick(1'b1);
    expect_val("move_x1", c_SEL_X1, 309);
    expect_val("move_x2", c_SEL_X2, 329);
    expect_val("move_y1", c_SEL_Y1, 231);
    expect_val("move_y2", c_SEL_Y2, 251);

    // Pause for 10 strobes
    in_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      tick(1'b1);
    end
    expect_val("pause_x1", c_SEL_X1, 309);
    expect_val("pause_y1", c_SEL_Y1, 231);
    expect_val("pause_state", c_SEL_STATE, 2);
    in_pause = 1'b0;
    tick(1'b0);

    // Rally with both paddles tracking; speed steps every 4 hits, caps at 6
    hits    = 0;
    n       = 0;
    prev_x  = int'(out_x1);
    prev_dx = -1;
    while (hits < 25 && n < 20000) begin
      in_leftbar_top  = 12'(track());
      in_rightbar_top = 12'(track());
      tick(1'b1);
      if (out_state != 3'd2) break;
      dx = int'(out_x1) - prev_x;
      if ((dx > 0) != (prev_dx > 0)) begin
        hits++;
        exp_spd = 1 + hits / 4;
        if (exp_spd > 6) exp_spd = 6;
        expect_val("rally_speed", c_SEL_SPEED, exp_spd);
      end
      prev_dx = dx;
      prev_x  = int'(out_x1);
      tick(1'b0);
      n++;
    end
    if (hits < 25) bound_fail("rally_hits", hits, 25);
    expect_val("rally_state", c_SEL_STATE, 2);

    // Left miss
    run_to_point(1'b1, "left_miss_wait");
    expect_val("lmiss_state", c_SEL_STATE, 3);
    expect_val("lmiss_point", c_SEL_POINT, 1);
    expect_val("lmiss_rscore", c_SEL_RSC, 1);
    expect_val("lmiss_lscore", c_SEL_LSC, 0);
    expect_centre("lmiss_ball");
    tick(1'b0);
    expect_val("lmiss_next_state", c_SEL_STATE, 1);
    expect_val("lmiss_point_off", c_SEL_POINT, 0);
    expect_val("lmiss_speed_rst", c_SEL_SPEED, 1);

    // Restart from SERVE
    in_start = 1'b1;
    tick(1'b0);
    in_start = 1'b0;
    expect_val("restart_state", c_SEL_STATE, 1);
    expect_val("restart_rscore", c_SEL_RSC, 0);

    // Left wins by nine right misses
    in_random = 4'b0000;
    for (int k = 1; k <= 9; k++) begin
      run_to_point(1'b0, "right_miss_wait");
      expect_val("rmiss_lscore", c_SEL_LSC, k);
      expect_val("rmiss_state", c_SEL_STATE, 3);
      expect_val("rmiss_point", c_SEL_POINT, 1);
      tick(1'b0);
      expect_val("post_point_state", c_SEL_STATE, (k == 9) ? 4 : 1);
      expect_val("post_point_winner", c_SEL_WIN, (k == 9) ? 1 : 0);
      expect_val("post_point_pulse", c_SEL_POINT, 0);
    end

    // OVER ignores strobes and holds the ball
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    expect_val("over_state", c_SEL_STATE, 4);
    expect_val("over_lscore", c_SEL_LSC, 9);
    expect_centre("over_ball");

    in_start = 1'b1;
    tick(1'b0);
    in_start = 1'b0;
    expect_val("over_restart_state", c_SEL_STATE, 1);
    expect_val("over_restart_lscore", c_SEL_LSC, 0);
    expect_val("over_restart_winner", c_SEL_WIN, 0);

    // Score a point, then reset asynchronously in the middle of the next rally
    in_random = 4'b0001;
    run_to_point(1'b1, "pre_reset_wait");
    expect_val("pre_reset_rscore", c_SEL_RSC, 1);
    tick(1'b0);
    for (int i = 0; i < 65; i++) begin
      in_leftbar_top  = 12'(track());
      in_rightbar_top = 12'(track());
      tick(1'b1);
      tick(1'b0);
    end
    expect_val("pre_reset_state", c_SEL_STATE, 2);
    in_reset_n = 1'b0;
    #2;
    expect_val("async_rst_state", c_SEL_STATE, 0);
    expect_centre("async_rst_ball");
    expect_val("async_rst_rscore", c_SEL_RSC, 0);
    expect_val("async_rst_speed", c_SEL_SPEED, 1);
    expect_val("async_rst_point", c_SEL_POINT, 0);
    expect_val("async_rst_winner", c_SEL_WIN, 0);
    @(posedge in_clock); #1;
    @(posedge in_clock); #1;
    in_reset_n = 1'b1;
    tick(1'b1);
    expect_val("post_rst_state", c_SEL_STATE, 0);

    repeat (3) @(negedge in_clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_ball_ctrl.md
PONG_BALL_CTRL -- requirements
Module: pong_ball_ctrl

Interface
REQ-001 SHALL have parameter COORD_W, default 12, coordinate width in bits.
REQ-002 SHALL have parameters H_SIZE=10, V_SIZE=10, IX=320, IY=240, BAR_WIDTH=20, BAR_LENGTH=180, D_WIDTH=639, D_HEIGHT=470, with the same meanings as for the existing ball block.
REQ-003 SHALL have parameters SPEED_MIN=1, SPEED_MAX=6 and HITS_PER_STEP=4: pixels per frame at serve, speed ceiling, and paddle hits per speed increment.
REQ-004 SHALL have parameters SCORE_W=4, WIN_SCORE=9 and SERVE_DELAY=60: score counter width, winning score, and serve wait in frames.
REQ-005 SHALL have ports, in order:
- in_clock  in  1  base clock
- in_reset_n  in  1  asynchronous, active-low reset
- in_ani_stb  in  1  one-cycle frame strobe
- in_start  in  1  start or restart a match
- in_pause  in  1  freeze motion while high
- in_random  in  4  external random bits
- in_leftbar_top, in_rightbar_top  in  COORD_W  paddle top edges
- out_x1, out_x2, out_y1, out_y2  out  COORD_W  ball edges
- out_left_score, out_right_score  out  SCORE_W  score counters
- out_speed  out  4  current speed
- out_state  out  3  FSM state encoding
- out_point  out  1  one-cycle pulse when a point is scored
- out_winner  out  2  01 = left wins, 10 = right wins, 00 = no winner

Function
REQ-006 SHALL implement FSM states IDLE=0, SERVE=1, PLAY=2, POINT=3 and OVER=4; out_state SHALL equal the current state.
REQ-007 IDLE: the ball is held at (IX,IY); in_start SHALL clear both scores and out_winner and go to SERVE.
REQ-008 SERVE: the ball is held at (IX,IY), speed=SPEED_MIN, hit count=0, and the frame counter counts in_ani_stb pulses.
REQ-009 When SERVE has seen SERVE_DELAY strobes, the FSM SHALL go to PLAY, with x_dir=in_random[0] and y_dir=in_random[1] sampled on that same cycle.
REQ-010 PLAY: on each in_ani_stb with in_pause low, x and y SHALL move by ±speed (x_dir 0 = right; y_dir 0 = down).
REQ-011 PLAY: while in_pause is high, x, y and all counters SHALL hold.
REQ-012 Vertical bounce:
- y1 <= speed forces y_dir=0.
- y2 >= D_HEIGHT-speed forces y_dir=1.
- Both are evaluated before the move within the same strobe.
REQ-013 Left contact when x1 <= BAR_WIDTH and x_dir=1:
- Hit if y2 >= in_leftbar_top and y1 <= in_leftbar_top+BAR_LENGTH: x_dir <= 0, hit count increments.
- Otherwise it is a miss.
REQ-014 Right contact is the mirror of REQ-013, using x2 >= D_WIDTH-BAR_WIDTH, x_dir=0 and in_rightbar_top.
REQ-015 On a hit that brings the hit count to HITS_PER_STEP, speed SHALL increment saturating at SPEED_MAX, and the hit count SHALL clear.
REQ-016 On a left miss, right score +1; on a right miss, left score +1.
REQ-017 On either miss, out_point SHALL pulse for exactly one cycle, the ball SHALL return to (IX,IY), and the FSM SHALL go to POINT; the position update is suppressed on that strobe.
REQ-018 POINT SHALL last one cycle, then go to OVER if either score equals WIN_SCORE, else to SERVE.
REQ-019 OVER: out_winner is set and the ball is held; in_start SHALL restart the match as in REQ-007.
REQ-020 in_start asserted in SERVE, PLAY or POINT SHALL restart the match as in REQ-007 on the next cycle.
REQ-021 in_start SHALL take priority over all other events in the same cycle.
REQ-022 Edges SHALL be x±H_SIZE and y±V_SIZE, combinational, truncated to COORD_W bits.
REQ-023 Paddle bottom sums SHALL be computed COORD_W+1 bits wide so no wrap occurs.
REQ-024 Scores SHALL saturate at 2^SCORE_W-1.
REQ-025 in_ani_stb SHALL be ignored outside SERVE and PLAY.

Reset
REQ-026 While in_reset_n is low, asynchronously:
- state=IDLE, x=IX, y=IY, x_dir=0, y_dir=0
- speed=SPEED_MIN, hit count=0, frame counter=0
- scores=0, out_point=0, out_winner=00
REQ-027 Reset asserted mid-PLAY SHALL abandon the rally with no score change recorded.
REQ-028 Reset release SHALL take effect on the first in_clock edge after in_reset_n goes high.

Configuration
REQ-029 With PONG_BALL_SPIN_EN defined, a hit whose centre y lies in the middle third of the paddle SHALL freeze vertical motion until the next hit.
REQ-030 With PONG_BALL_SPIN_EN defined, a hit in the outer thirds SHALL set y_dir from in_random[2] (left paddle) or in_random[3] (right paddle) and unfreeze vertical motion.
REQ-031 Without PONG_BALL_SPIN_EN, a hit SHALL leave y_dir unchanged and never freeze vertical motion.

Verification
REQ-032 Apply reset, then in_start, with SERVE_DELAY=60 -> out_state=1 for 60 strobes, then 2; ball at (320,240) throughout SERVE.
REQ-033 Left paddle at top 200, ball moving left at y=240 -> bounce with x_dir=0; after 4 hits out_speed=2; after 25 hits out_speed stays at 6.
REQ-034 Left paddle at top 0, ball moving left at y=400 -> one-cycle out_point, out_right_score=1, ball at (320,240), state 3 then 1.
REQ-035 Left score at 8 and a right miss -> out_left_score=9, out_winner=01, state=4; in_start -> scores 0, out_winner=00, state=1.
REQ-036 in_pause held for 10 strobes in PLAY -> x and y unchanged; in_reset_n pulsed low mid-PLAY -> all outputs return to REQ-026 values with no clock edge required.
